// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding, reset-cause
// bit positions and a counter-width helper.
package reset_seq_pkg;

   // State encoding
   localparam logic [1:0] ST_ASSERT = 2'd0;
   localparam logic [1:0] ST_STAGE  = 2'd1;
   localparam logic [1:0] ST_RUN    = 2'd2;

   typedef enum logic [1:0] {
      SEQ_ASSERT = ST_ASSERT,
      SEQ_STAGE  = ST_STAGE,
      SEQ_RUN    = ST_RUN
   } seq_state_t;

   // Bit positions inside the 4-bit cause register
   localparam int unsigned CAUSE_POR = 0;
   localparam int unsigned CAUSE_BTN = 1;
   localparam int unsigned CAUSE_WDT = 2;
   localparam int unsigned CAUSE_SW  = 3;
   localparam int unsigned CAUSE_W   = 4;

   // Width of a counter that must hold values up to max_count
   function automatic int unsigned cnt_width(input int unsigned max_count);
      return $clog2(max_count) + 1;
   endfunction

endpackage

// File: rtl/rst_debounce.sv
// Push-button conditioner: two-flop synchroniser followed by a debounce
// counter. The debounced level only changes after DEB_CYC consecutive
// synchronised samples disagree with it; press pulses for one cycle on the
// debounced falling edge.
//   clk        system clock
//   rst        async active-high reset (presets to "button released")
//   btn_rst_n  raw active-low button, asynchronous to clk
//   btn_db     debounced level (1 = released), registered
//   press      one-cycle pulse on a debounced press, registered
module rst_debounce
   import reset_seq_pkg::*;
#(
   parameter int unsigned DEB_CYC = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_rst_n,
   output logic btn_db,
   output logic press
);

   localparam int unsigned CW = cnt_width(DEB_CYC);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   // Synchroniser, disagreement counter and debounced level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1  <= 1'b1;
         sync2  <= 1'b1;
         btn_db <= 1'b1;
         press  <= 1'b0;
         cnt    <= '0;
      end else begin
         sync1 <= btn_rst_n;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 == btn_db) begin
            // any agreeing sample restarts the count, so glitches are ignored
            cnt <= '0;
         end else if (cnt == CW'(DEB_CYC - 1)) begin
            btn_db <= sync2;
            press  <= ~sync2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/reset_sequencer.sv
// Central reset controller. Merges power-on, push-button, watchdog and
// software reset sources, holds all downstream domains in reset for
// HOLD_CYC cycles, then releases them one by one (index 0 first) every
// STAGE_DLY cycles. The cause of the most recent reset is kept for firmware.
//   clk        system clock
//   rst        async active-high power-on / external reset
//   btn_rst_n  raw push-button, active low
//   sw_rst     one-cycle software reset request
//   wdog_kick  one-cycle watchdog restart
//   rst_o      staged domain resets, active high, registered
//   ready      all stages released, registered
//   cause      last reset cause {SW,WDT,BTN,POR}, registered, sticky
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int unsigned NSTAGE    = 3,
   parameter int unsigned HOLD_CYC  = 16,
   parameter int unsigned STAGE_DLY = 8,
   parameter int unsigned DEB_CYC   = 1024,
   parameter int unsigned WDOG_CYC  = 65536,
   parameter bit          WDOG_EN   = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              btn_rst_n,
   input  logic              sw_rst,
   input  logic              wdog_kick,
   output logic [NSTAGE-1:0] rst_o,
   output logic              ready,
   output logic [CAUSE_W-1:0] cause
);

   localparam int unsigned CNT_MAX = (HOLD_CYC > STAGE_DLY) ? HOLD_CYC : STAGE_DLY;
   localparam int unsigned CW      = cnt_width(CNT_MAX);
   localparam int unsigned STGW    = cnt_width(NSTAGE);
   localparam int unsigned WW      = cnt_width(WDOG_CYC);

   seq_state_t           state;
   logic [CW-1:0]        cnt;
   logic [STGW-1:0]      stg;
   logic                 btn_db;
   logic                 press;
   logic                 wdog_to;
   logic                 trig;
   logic [CAUSE_W-1:0]   trig_cause;

   rst_debounce #(
      .DEB_CYC (DEB_CYC)
   ) u_debounce (
      .clk       (clk),
      .rst       (rst),
      .btn_rst_n (btn_rst_n),
      .btn_db    (btn_db),
      .press     (press)
   );

   // Watchdog: counts only in RUN; a kick on the would-be timeout cycle wins
   generate
      if (WDOG_EN) begin : g_wdog
         logic [WW-1:0] wcnt;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               wcnt <= '0;
            end else if (state != SEQ_RUN || wdog_kick) begin
               wcnt <= '0;
            end else if (wcnt != WW'(WDOG_CYC - 1)) begin
               wcnt <= wcnt + WW'(1);
            end
         end

         // fires on the edge where the count would reach WDOG_CYC-1
         assign wdog_to = (state == SEQ_RUN) && !wdog_kick &&
                          (wcnt == WW'(WDOG_CYC - 2));
      end else begin : g_no_wdog
         assign wdog_to = 1'b0;
      end
   endgenerate

   // Sources firing this cycle; POR bit is never set by a runtime trigger
   always_comb begin
      trig_cause            = '0;
      trig_cause[CAUSE_BTN] = press;
      trig_cause[CAUSE_WDT] = wdog_to;
      trig_cause[CAUSE_SW]  = sw_rst;
   end

   assign trig = |trig_cause;

   // Sequencer FSM with registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= SEQ_ASSERT;
         rst_o            <= '1;
         ready            <= 1'b0;
         cause            <= '0;
         cause[CAUSE_POR] <= 1'b1;
         cnt              <= '0;
         stg              <= '0;
      end else if (trig) begin
         // any trigger restarts the whole sequence, re-asserting released stages
         state <= SEQ_ASSERT;
         rst_o <= '1;
         ready <= 1'b0;
         cause <= trig_cause;
         cnt   <= '0;
         stg   <= '0;
      end else begin
         case (state)
            SEQ_ASSERT: begin
               rst_o <= '1;
               ready <= 1'b0;
               if (!btn_db) begin
                  // hold time only starts once the button is released
                  cnt <= '0;
               end else if (cnt == CW'(HOLD_CYC - 1)) begin
                  rst_o[0] <= 1'b0;
                  cnt      <= '0;
                  stg      <= STGW'(1);
                  state    <= SEQ_STAGE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            SEQ_STAGE: begin
               if (cnt == CW'(STAGE_DLY - 1)) begin
                  rst_o <= rst_o & ~(NSTAGE'(1) << stg);
                  cnt   <= '0;
                  if (stg == STGW'(NSTAGE - 1)) begin
                     ready <= 1'b1;
                     state <= SEQ_RUN;
                  end else begin
                     stg <= stg + STGW'(1);
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            SEQ_RUN: begin
               rst_o <= '0;
               ready <= 1'b1;
               cnt   <= '0;
               stg   <= '0;
            end

            default: begin
               state <= SEQ_ASSERT;
               rst_o <= '1;
               ready <= 1'b0;
               cnt   <= '0;
               stg   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer. A timing-based reference model
// predicts rst_o/ready/cause from edge numbers of the last trigger, the
// debounced button window and the last watchdog clear.
module tb_reset_sequencer;

   localparam int NSTAGE = 3;
   localparam int HOLD   = 4;
   localparam int DLY    = 2;
   localparam int DEB    = 4;
   localparam int WDOG   = 20;
   localparam int NEVER  = -1000000;

   logic              clk = 1'b0;
   logic              rst;
   logic              btn_rst_n;
   logic              sw_rst;
   logic              wdog_kick;
   logic [NSTAGE-1:0] rst_o;
   logic              ready;
   logic [3:0]        cause;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   reset_sequencer #(
      .NSTAGE    (NSTAGE),
      .HOLD_CYC  (HOLD),
      .STAGE_DLY (DLY),
      .DEB_CYC   (DEB),
      .WDOG_CYC  (WDOG),
      .WDOG_EN   (1'b1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_rst_n (btn_rst_n),
      .sw_rst    (sw_rst),
      .wdog_kick (wdog_kick),
      .rst_o     (rst_o),
      .ready     (ready),
      .cause     (cause)
   );

   // ---------------- reference model ----------------
   int                ed;        // edges since rst fell
   int                base;      // edge from which the hold time is counted
   int                wd_clear;  // last watchdog kick inside RUN
   logic [3:0]        m_cause;
   logic              db;
   logic              press_d;
   logic              smp [$];   // raw button samples, newest first
   logic [NSTAGE-1:0] m_rst;
   logic              m_ready;
   int                run_entry;
   int                wd_ref;
   bit                in_run, wd_to, fire, flip;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ed = 0; base = 0; wd_clear = NEVER;
         m_cause = 4'b0001; db = 1'b1; press_d = 1'b0;
         smp.delete();
         for (int j = 0; j < 2 + DEB; j++) smp.push_back(1'b1);
      end else begin
         ed++;
         run_entry = base + HOLD + (NSTAGE - 1) * DLY;
         in_run    = ed > run_entry;
         wd_ref    = (wd_clear > run_entry) ? wd_clear : run_entry;
         wd_to     = in_run && !wdog_kick && (ed == wd_ref + WDOG - 1);
         fire      = press_d || sw_rst || wd_to;
         if (fire) begin
            base     = ed;
            wd_clear = NEVER;
            m_cause  = {sw_rst, wd_to, press_d, 1'b0};
         end else begin
            if (!db && ed <= base + HOLD) base = ed;
            if (in_run && wdog_kick) wd_clear = ed;
         end
         // button: level flips when the last DEB synchronised samples all disagree
         smp.push_front(btn_rst_n);
         void'(smp.pop_back());
         flip = 1'b1;
         for (int j = 2; j < 2 + DEB; j++) if (smp[j] == db) flip = 1'b0;
         press_d = flip && db;
         if (flip) db = ~db;
      end
      for (int k = 0; k < NSTAGE; k++) m_rst[k] = !(ed >= base + HOLD + k * DLY);
      m_ready = ed >= base + HOLD + (NSTAGE - 1) * DLY;
   end

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [NSTAGE:0] want;
      rst = 1'b1; btn_rst_n = 1'b1; sw_rst = 1'b0; wdog_kick = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({rst_o, ready, cause} !== {3'b111, 1'b0, 4'b0001}) begin
         n_bad++;
         $display("FAIL reset_hold: got rst_o=%b ready=%b cause=%b, expected 111 0 0001", rst_o, ready, cause);
      end
      rst = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         @(negedge clk);
         n_cmp++;
         if ({rst_o, ready, cause} !== {m_rst, m_ready, m_cause}) begin
            n_bad++;
            $display("FAIL por edge %0d: got %b %b %b, expected %b %b %b", e, rst_o, ready, cause, m_rst, m_ready, m_cause);
         end
         if (e == 3 || e == 4 || e == 6 || e == 8) begin
            want = (e == 3) ? 4'b1110 : (e == 4) ? 4'b1100 : (e == 6) ? 4'b1000 : 4'b0001;
            n_cmp++;
            if ({rst_o, ready} !== want) begin
               n_bad++;
               $display("FAIL por_release edge %0d: got {rst_o,ready}=%b, expected %b", e, {rst_o, ready}, want);
            end
         end
      end
   endtask

   task automatic test_sw();
      logic [NSTAGE:0] want;
      repeat ($urandom_range(1, 6)) begin
         wdog_kick = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      wdog_kick = 1'b0;
      for (int i = 0; i < 12; i++) begin
         sw_rst = (i == 0);
         @(negedge clk);
         n_cmp++;
         if ({rst_o, ready, cause} !== {m_rst, m_ready, m_cause}) begin
            n_bad++;
            $display("FAIL sw N+%0d: got %b %b %b, expected %b %b %b", i, rst_o, ready, cause, m_rst, m_ready, m_cause);
         end
         if (i == 0 || i == 4 || i == 6 || i == 8) begin
            want = (i == 0) ? 4'b1110 : (i == 4) ? 4'b1100 : (i == 6) ? 4'b1000 : 4'b0001;
            n_cmp++;
            if ({rst_o, ready} !== want || cause !== 4'b1000) begin
               n_bad++;
               $display("FAIL sw_seq N+%0d: got %b cause=%b, expected %b cause=1000", i, {rst_o, ready}, cause, want);
            end
         end
      end
      sw_rst = 1'b0;
   endtask

   task automatic test_wdog();
      int period;
      period = int'($urandom_range(5, 15));
      for (int i = 0; i < 100; i++) begin
         wdog_kick = (i % period == 0) || (i == 99);
         @(negedge clk);
         n_cmp++;
         if ({rst_o, ready, cause} !== {m_rst, m_ready, m_cause} || ready !== 1'b1) begin
            n_bad++;
            $display("FAIL wdog_kicked i=%0d: got %b %b %b, expected %b 1 %b", i, rst_o, ready, cause, m_rst, m_cause);
         end
      end
      wdog_kick = 1'b0;
      for (int j = 1; j <= 24; j++) begin
         @(negedge clk);
         n_cmp++;
         if ({rst_o, ready, cause} !== {m_rst, m_ready, m_cause}) begin
            n_bad++;
            $display("FAIL wdog K+%0d: got %b %b %b, expected %b %b %b", j, rst_o, ready, cause, m_rst, m_ready, m_cause);
         end
         if (j == 18) begin
            n_cmp++;
            if ({rst_o, ready} !== 4'b0001) begin
               n_bad++;
               $display("FAIL wdog_early: got {rst_o,ready}=%b, expected 0001", {rst_o, ready});
            end
         end
         if (j == 19) begin
            n_cmp++;
            if ({rst_o, ready, cause} !== {3'b111, 1'b0, 4'b0100}) begin
               n_bad++;
               $display("FAIL wdog_timeout: got %b %b %b, expected 111 0 0100", rst_o, ready, cause);
            end
         end
      end
   endtask

   task automatic test_button();
      int len;
      for (int i = 0; i < 8; i++) begin
         wdog_kick = (i == 7);
         @(negedge clk);
         n_cmp++;
         if ({rst_o, ready, cause} !== {m_rst, m_ready, m_cause}) begin
            n_bad++;
            $display("FAIL btn_settle i=%0d: got %b %b %b, expected %b %b %b", i, rst_o, ready, cause, m_rst, m_ready, m_cause);
         end
      end
      for (int g = 0; g < 3; g++) begin
         len = int'($urandom_range(1, DEB - 1));
         for (int i = 0; i < len + 6; i++) begin
            btn_rst_n = (i >= len);
            wdog_kick = (i == 0);
            @(negedge clk);
            n_cmp++;
            if ({rst_o, ready, cause} !== {m_rst, m_ready, m_cause} || ready !== 1'b1) begin
               n_bad++;
               $display("FAIL btn_glitch len=%0d i=%0d: got %b %b %b, expected %b 1 %b", len, i, rst_o, ready, cause, m_rst, m_cause);
            end
         end
      end
      for (int e = 1; e <= 40; e++) begin
         btn_rst_n = (e > 12);
         wdog_kick = (e % 8 == 0);
         @(negedge clk);
         n_cmp++;
         if ({rst_o, ready, cause} !== {m_rst, m_ready, m_cause}) begin
            n_bad++;
            $display("FAIL btn_hold e=%0d: got %b %b %b, expected %b %b %b", e, rst_o, ready, cause, m_rst, m_ready, m_cause);
         end
         if (e == 6 || e == 7 || e == 21 || e == 22 || e == 26) begin
            n_cmp++;
            if ((e == 6  && ready !== 1'b1) ||
                (e == 7  && {rst_o, ready, cause} !== {3'b111, 1'b0, 4'b0010}) ||
                (e == 21 && rst_o !== 3'b111) ||
                (e == 22 && rst_o !== 3'b110) ||
                (e == 26 && {rst_o, ready} !== 4'b0001)) begin
               n_bad++;
               $display("FAIL btn_timing e=%0d: got rst_o=%b ready=%b cause=%b", e, rst_o, ready, cause);
            end
         end
      end
      wdog_kick = 1'b0;
   endtask

   task automatic test_retrigger();
      repeat ($urandom_range(0, 3)) begin
         wdog_kick = 1'b1;
         @(negedge clk);
      end
      wdog_kick = 1'b0;
      for (int i = 0; i < 20; i++) begin
         sw_rst = (i == 0) || (i == 7);
         @(negedge clk);
         n_cmp++;
         if ({rst_o, ready, cause} !== {m_rst, m_ready, m_cause}) begin
            n_bad++;
            $display("FAIL retrig N+%0d: got %b %b %b, expected %b %b %b", i, rst_o, ready, cause, m_rst, m_ready, m_cause);
         end
         if (i == 6 || i == 7 || i == 11 || i == 15) begin
            n_cmp++;
            if ((i == 6  && rst_o !== 3'b100) ||
                (i == 7  && {rst_o, ready} !== 4'b1110) ||
                (i == 11 && rst_o !== 3'b110) ||
                (i == 15 && {rst_o, ready} !== 4'b0001)) begin
               n_bad++;
               $display("FAIL retrig_seq N+%0d: got rst_o=%b ready=%b", i, rst_o, ready);
            end
         end
      end
      sw_rst = 1'b0;
   endtask

   task automatic test_simultaneous();
      for (int j = 0; j <= 24; j++) begin
         wdog_kick = (j == 0);
         sw_rst    = (j == 19);
         @(negedge clk);
         n_cmp++;
         if ({rst_o, ready, cause} !== {m_rst, m_ready, m_cause}) begin
            n_bad++;
            $display("FAIL simul K+%0d: got %b %b %b, expected %b %b %b", j, rst_o, ready, cause, m_rst, m_ready, m_cause);
         end
         if (j == 19) begin
            n_cmp++;
            if ({rst_o, ready, cause} !== {3'b111, 1'b0, 4'b1100}) begin
               n_bad++;
               $display("FAIL simul_cause: got %b %b %b, expected 111 0 1100", rst_o, ready, cause);
            end
         end
      end
      sw_rst = 1'b0; wdog_kick = 1'b0;
      n_cmp++;
      if (rst_o !== 3'b110) begin
         n_bad++;
         $display("FAIL pre_async_stage: got rst_o=%b, expected 110", rst_o);
      end
      // async reset between clock edges
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({rst_o, ready, cause} !== {3'b111, 1'b0, 4'b0001}) begin
         n_bad++;
         $display("FAIL async_rst: got %b %b %b, expected 111 0 0001", rst_o, ready, cause);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         @(negedge clk);
         n_cmp++;
         if ({rst_o, ready, cause} !== {m_rst, m_ready, m_cause}) begin
            n_bad++;
            $display("FAIL por2 edge %0d: got %b %b %b, expected %b %b %b", e, rst_o, ready, cause, m_rst, m_ready, m_cause);
         end
         if (e == 8) begin
            n_cmp++;
            if ({rst_o, ready, cause} !== {3'b000, 1'b1, 4'b0001}) begin
               n_bad++;
               $display("FAIL por2_ready: got %b %b %b, expected 000 1 0001", rst_o, ready, cause);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_sw();
      test_wdog();
      test_button();
      test_retrigger();
      test_simultaneous();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
